ram_bank_reader: RTL and testbench
==================================

# ram_bank_reader

Read-side sequencer for a `ram_bank` instance. It accepts a burst command (start address and length) and issues `re`/`addr_r` to the bank. It absorbs the bank's one-cycle registered read latency and streams the words out on a valid/ready interface with full backpressure. It sits between a `ram_bank` and any downstream consumer, such as a DMA or an output serializer, and is the counterpart of the write path that fills the bank.

## Interface
- `ADDR_BIT`, 3, bank address width.
- `DATA_BIT`, 16, word width.
- `MEM_HEIGHT`, 8, bank depth in words. Must satisfy MEM_HEIGHT ≤ 2^ADDR_BIT.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset. Synchronous, active-low.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  reader idle; command accepted when `cmd_valid && cmd_ready`.
- `cmd_addr`  in  ADDR_BIT  start address.
- `cmd_len`  in  ADDR_BIT+1  word count, 0..MEM_HEIGHT.
- `cmd_err`  out  1  one-cycle pulse: command rejected.
- `ram_en`  out  1  to bank `en`. Equals `ram_re`.
- `ram_re`  out  1  to bank `re`.
- `ram_addr_r`  out  ADDR_BIT  to bank `addr_r`.
- `ram_d_r`  in  DATA_BIT  from bank `d_r`. Valid the cycle after `ram_re`.
- `out_valid`  out  1  stream word valid.
- `out_ready`  in  1  consumer accepts.
- `out_data`  out  DATA_BIT  stream word.
- `out_last`  out  1  qualifies the final word of a burst.
- `busy`  out  1  burst in progress (not IDLE).

## Operation
- **States:**
  - IDLE: `cmd_ready`=1.
  - READ: issuing reads.
  - DRAIN: all reads issued, waiting for the FIFO to empty.
- **Accept in IDLE:**
  - `cmd_len`=0: command is a no-op; the block stays in IDLE.
  - Otherwise: latch address and remaining count, then go to READ.
- **Issue rule in READ:**
  - `ram_re`=1 iff remaining>0 and (fifo_count + inflight < 2, or a pop occurs this cycle).
  - On each issue: address increments and remaining decrements.
  - After the last issue the state moves to READ→DRAIN.
- **Capture:** a 1-bit `inflight` register is set on issue. The cycle after, `ram_d_r` is pushed into a 2-entry FIFO. The FIFO can never overflow.
- **out_last:** asserted on the word whose index equals the burst length minus 1.
- **Burst end:** DRAIN→IDLE on the `out_valid && out_ready && out_last` handshake. `cmd_ready` rises in the following cycle.
- **Output rule:** `out_data`/`out_last` hold stable while `out_valid && !out_ready`.
- **Address arithmetic:** unsigned, ADDR_BIT wide. Wrap behaviour is set per Configuration.
- **Simultaneous events:**
  - Push and pop in the same cycle leave the count unchanged.
  - A command offered while busy is ignored; `cmd_ready`=0.

## Timing
- **Reset values:** `cmd_ready`=1 (IDLE), `cmd_err`=0, `ram_en`/`ram_re`=0, `ram_addr_r`=0, `out_valid`=0, `out_data`=0, `out_last`=0, `busy`=0. FIFO and `inflight` are cleared.
- **Reset mid-burst:** the burst is abandoned. The bank word returned the next cycle is discarded because `inflight` is cleared.
- **Latency:** command accepted at edge T. First `ram_re` during cycle T+1, data on `ram_d_r` at T+2, `out_valid` at T+3.
- **Throughput:** 1 word/cycle with `out_ready` held high. An N-word burst completes its last handshake at cycle T+N+2.
- **Backpressure:** with `out_ready` low, at most 2 words are buffered and reads stall. Reads resume in the same cycle `out_ready` returns.

## Configuration
- `RAM_BANK_READER_WRAP_EN` defined: address wraps from MEM_HEIGHT-1 to 0. Any `cmd_addr` < MEM_HEIGHT with any `cmd_len` ≤ MEM_HEIGHT is legal. `cmd_err` is tied 0.
- Undefined:
  - A command is rejected if `cmd_addr + cmd_len > MEM_HEIGHT`, `cmd_addr` ≥ MEM_HEIGHT, or `cmd_len` > MEM_HEIGHT.
  - On rejection, `cmd_err` pulses one cycle after acceptance and the state stays IDLE.

## Structure
- **Package `ram_bank_pkg`:** ADDR_BIT/DATA_BIT/MEM_HEIGHT defaults and the state encoding (IDLE/READ/DRAIN). Shared with the write-side block.
- **Sub-module `rd_skid_fifo`:** 2-entry FIFO with push, pop, count, and registered head.

## Test plan
- Reset, then a command of addr=2, len=4 with the bank preloaded with mem[i]=0x1000+i and `out_ready`=1. Required: words 0x1002..0x1005 on `out_data` at T+3..T+6, `out_last` only on 0x1005, `cmd_ready` back at 1 at T+7.
- Same burst with `out_ready` toggling 1,0,0,1: no word lost or duplicated, `ram_re` stalls while FIFO count + inflight = 2, data held stable while stalled.
- Command addr=6, len=4:
  - WRAP_EN defined: words mem[6], mem[7], mem[0], mem[1].
  - Undefined: `cmd_err` pulse, no `ram_re`, `busy` stays 0.
- `cmd_len`=0 → no `ram_re`, no `out_valid`, `cmd_ready` stays 1. A `cmd_valid` during a burst is ignored.
- `rst_n` low for one cycle after the 2nd word of a len-8 burst → all outputs at reset values the next cycle, no stale word emitted, and a new len-1 burst afterwards returns the correct word.

Source files
------------

// File: rtl/ram_bank_pkg.sv
// Shared defaults and read-sequencer state encoding for the ram_bank read/write
// blocks.
package ram_bank_pkg;

  localparam int ADDR_BIT_DEF   = 3;
  localparam int DATA_BIT_DEF   = 16;
  localparam int MEM_HEIGHT_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_t;

endpackage

// File: rtl/rd_skid_fifo.sv
// Two-entry FIFO with a registered head. It captures words returning from the
// bank and presents the oldest one to the stream.
module rd_skid_fifo #(
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [1:0]       count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] tail;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: storage is reset on purpose; the head drives out_data, which must read 0 after reset.
      count <= 2'd0;
      head  <= '0;
      tail  <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) head <= din;
          else               tail <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          // Simultaneous push and pop: occupancy is unchanged, and the queue shifts.
          if (count == 2'd2) begin
            head <= tail;
            tail <= din;
          end else begin
            head <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ram_bank_reader.sv
// Burst read sequencer for a ram_bank. It issues re/addr_r, absorbs the bank's
// one-cycle read latency and streams words out over valid/ready.
// The optional macro RAM_BANK_READER_WRAP_EN enables address wrap at MEM_HEIGHT-1.
module ram_bank_reader
  import ram_bank_pkg::*;
#(
  parameter int ADDR_BIT   = ADDR_BIT_DEF,
  parameter int DATA_BIT   = DATA_BIT_DEF,
  parameter int MEM_HEIGHT = MEM_HEIGHT_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ADDR_BIT-1:0] cmd_addr,
  input  logic [ADDR_BIT:0]   cmd_len,
  output logic                cmd_err,
  output logic                ram_en,
  output logic                ram_re,
  output logic [ADDR_BIT-1:0] ram_addr_r,
  input  logic [DATA_BIT-1:0] ram_d_r,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_BIT-1:0] out_data,
  output logic                out_last,
  output logic                busy
);

  localparam int RW = ADDR_BIT + 1;

  rd_state_t           state;
  logic [ADDR_BIT-1:0] addr;
  logic [ADDR_BIT-1:0] addr_next;
  logic [ADDR_BIT:0]   remaining;
  logic                inflight;
  logic                inflight_last;
  logic [1:0]          fifo_count;
  logic [DATA_BIT:0]   head;
  logic                accept;
  logic                pop;
  logic                issue;
  logic                cmd_bad;

`ifdef RAM_BANK_READER_WRAP_EN
  localparam logic [ADDR_BIT-1:0] LAST_ADDR = ADDR_BIT'(MEM_HEIGHT - 1);
  assign cmd_bad   = 1'b0;
  assign addr_next = (addr == LAST_ADDR) ? '0 : addr + ADDR_BIT'(1);
`else
  localparam int                  HW     = ADDR_BIT + 2;
  localparam logic [ADDR_BIT+1:0] HEIGHT = HW'(MEM_HEIGHT);
  assign cmd_bad   = ({2'b00, cmd_addr} >= HEIGHT) ||
                     ({1'b0, cmd_len} > HEIGHT) ||
                     (({2'b00, cmd_addr} + {1'b0, cmd_len}) > HEIGHT);
  assign addr_next = addr + ADDR_BIT'(1);
`endif

  assign accept    = cmd_valid && (state == ST_IDLE);
  assign pop       = out_valid && out_ready;
  // Words already committed (in the FIFO or returning from the bank) never exceed the FIFO depth.
  assign issue     = (state == ST_READ) && (remaining != '0) &&
                     ((({1'b0, fifo_count} + {2'b00, inflight}) < 3'd2) || pop);

  assign ram_re     = issue;
  assign ram_en     = issue;
  assign ram_addr_r = addr;
  assign cmd_ready  = (state == ST_IDLE);
  assign busy       = (state != ST_IDLE);
  assign out_valid  = (fifo_count != 2'd0);
  assign out_data   = head[DATA_BIT-1:0];
  assign out_last   = out_valid && head[DATA_BIT];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      addr          <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      cmd_err       <= 1'b0;
    end else begin
      cmd_err       <= accept && cmd_bad;
      inflight      <= issue;
      inflight_last <= issue && (remaining == RW'(1));
      case (state)
        ST_IDLE: begin
          if (accept && !cmd_bad && (cmd_len != '0)) begin
            addr      <= cmd_addr;
            remaining <= cmd_len;
            state     <= ST_READ;
          end
        end
        ST_READ: begin
          if (issue) begin
            addr      <= addr_next;
            remaining <= remaining - RW'(1);
            if (remaining == RW'(1)) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (pop && out_last) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  rd_skid_fifo #(
    .WIDTH(DATA_BIT + 1)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (inflight),
    .din  ({inflight_last, ram_d_r}),
    .pop  (pop),
    .count(fifo_count),
    .head (head)
  );

endmodule

// File: tb/tb_ram_bank_reader.sv
// Scoreboard bench for ram_bank_reader with a behavioural one-cycle-latency
// bank model. Build with RAM_BANK_READER_WRAP_EN to exercise the wrap variant.
module tb_ram_bank_reader;

  localparam int AB = 3;
  localparam int DB = 16;
  localparam int MH = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [AB-1:0] cmd_addr = '0;
  logic [AB:0]   cmd_len = '0;
  logic          out_ready = 1'b0;
  logic [DB-1:0] ram_d_r = 16'hDEAD;
  logic          cmd_ready, cmd_err, ram_en, ram_re, out_valid, out_last, busy;
  logic [AB-1:0] ram_addr_r;
  logic [DB-1:0] out_data;

  logic [DB-1:0] mem [MH];
  logic [DB:0]   exp_q [$];
  int            passed = 0;
  int            total = 0;

  always #5 clk = ~clk;

  ram_bank_reader #(.ADDR_BIT(AB), .DATA_BIT(DB), .MEM_HEIGHT(MH)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_err(cmd_err),
    .ram_en(ram_en), .ram_re(ram_re), .ram_addr_r(ram_addr_r), .ram_d_r(ram_d_r),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy)
  );

  // Bank: registered read, word appears the cycle after re.
  always @(posedge clk) if (ram_en && ram_re) ram_d_r <= mem[ram_addr_r];

  function automatic logic [AB-1:0] next_addr(input logic [AB-1:0] a);
`ifdef RAM_BANK_READER_WRAP_EN
    return (int'(a) == MH - 1) ? '0 : a + AB'(1);
`else
    return a + AB'(1);
`endif
  endfunction

  // mode 0: ready always high, 1: ready pattern 1,0,0,1, 2: random ready.
  task automatic run_burst(input int addr, input int len, input int mode,
                           input bit junk, input bit timing);
    int            rem, k, first_k, last_k;
    int            iss_q [$];
    logic [AB-1:0] a;
    logic          exp_re, exp_valid, hsk, stall, prev_last;
    logic [DB-1:0] prev_data;
    logic [DB:0]   e;
    a = AB'(addr);
    for (int i = 0; i < len; i++) begin
      exp_q.push_back({(i == len - 1), mem[a]});
      a = next_addr(a);
    end
    a = AB'(addr);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = AB'(addr); cmd_len = (AB+1)'(len);
    total++;
    if (cmd_ready !== 1'b1) $display("FAIL cmd_ready_before_cmd got %b want 1", cmd_ready);
    else passed++;
    @(negedge clk);
    rem = len; k = 1; first_k = 0; last_k = 0; stall = 1'b0;
    prev_data = '0; prev_last = 1'b0;
    while (exp_q.size() > 0 && k <= 200) begin
      cmd_valid = junk;
      if (junk) begin cmd_addr = 3'd5; cmd_len = 4'd2; end
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (k % 4 == 1) || (k % 4 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      exp_valid = (iss_q.size() > 0) && (iss_q[0] <= k - 2);
      hsk       = exp_valid && out_ready;
      exp_re    = (rem > 0) && ((iss_q.size() < 2) || hsk);
      total++;
      if (ram_re !== exp_re || ram_en !== exp_re)
        $display("FAIL re k=%0d got re=%b en=%b want %b", k, ram_re, ram_en, exp_re);
      else passed++;
      if (exp_re) begin
        total++;
        if (ram_addr_r !== a) $display("FAIL addr k=%0d got %0d want %0d", k, ram_addr_r, a);
        else passed++;
      end
      total++;
      if (out_valid !== exp_valid) $display("FAIL out_valid k=%0d got %b want %b", k, out_valid, exp_valid);
      else passed++;
      if (junk) begin
        total++;
        if (cmd_ready !== 1'b0 || busy !== 1'b1)
          $display("FAIL busy_ignore k=%0d got ready=%b busy=%b want 0/1", k, cmd_ready, busy);
        else passed++;
      end
      if (stall) begin
        total++;
        if (out_data !== prev_data || out_last !== prev_last)
          $display("FAIL hold k=%0d got %h/%b want %h/%b", k, out_data, out_last, prev_data, prev_last);
        else passed++;
      end
      if (hsk) begin
        e = exp_q.pop_front();
        total++;
        if (out_data !== e[DB-1:0] || out_last !== e[DB])
          $display("FAIL word k=%0d got %h last=%b want %h last=%b", k, out_data, out_last, e[DB-1:0], e[DB]);
        else passed++;
        if (first_k == 0) first_k = k;
        last_k = k;
        void'(iss_q.pop_front());
      end
      if (exp_re) begin
        rem--;
        a = next_addr(a);
        iss_q.push_back(k);
      end
      stall     = exp_valid && !out_ready;
      prev_data = out_data;
      prev_last = out_last;
      if (exp_q.size() == 0) cmd_valid = 1'b0;
      @(negedge clk);
      k++;
    end
    cmd_valid = 1'b0;
    if (exp_q.size() != 0) begin
      total++;
      $display("FAIL burst_timeout got %0d words left want 0", exp_q.size());
      exp_q.delete();
    end
    #1;
    total++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL burst_end got ready=%b busy=%b valid=%b want 1/0/0", cmd_ready, busy, out_valid);
    else passed++;
    if (timing) begin
      total++;
      if (first_k !== 3 || last_k !== len + 2)
        $display("FAIL latency got first=%0d last=%0d want 3/%0d", first_k, last_k, len + 2);
      else passed++;
    end
  endtask

  task automatic check_reset_values(input string tag);
    total++;
    if (cmd_ready !== 1'b1 || cmd_err !== 1'b0 || ram_en !== 1'b0 || ram_re !== 1'b0 ||
        ram_addr_r !== '0 || out_valid !== 1'b0 || out_data !== '0 || out_last !== 1'b0 ||
        busy !== 1'b0)
      $display("FAIL %s got rdy=%b err=%b en=%b re=%b a=%0d v=%b d=%h l=%b busy=%b want 1,0,0,0,0,0,0000,0,0",
               tag, cmd_ready, cmd_err, ram_en, ram_re, ram_addr_r, out_valid, out_data, out_last, busy);
    else passed++;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("reset_held");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_values("reset_released");
  endtask

  task automatic test_basic;
    run_burst(2, 4, 0, 1'b0, 1'b1);
  endtask

  task automatic test_backpressure;
    run_burst(2, 4, 1, 1'b0, 1'b0);
    run_burst(0, 8, 2, 1'b0, 1'b0);
  endtask

  task automatic test_boundary;
    run_burst(4, 4, 0, 1'b0, 1'b1);
    run_burst(7, 1, 0, 1'b0, 1'b1);
  endtask

  task automatic test_addr_overflow;
`ifdef RAM_BANK_READER_WRAP_EN
    run_burst(6, 4, 0, 1'b0, 1'b1);
`else
    out_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = 3'd6; cmd_len = 4'd4;
    @(negedge clk);
    cmd_valid = 1'b0;
    total++;
    if (cmd_err !== 1'b1 || ram_re !== 1'b0 || busy !== 1'b0)
      $display("FAIL cmd_err_pulse got err=%b re=%b busy=%b want 1/0/0", cmd_err, ram_re, busy);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (cmd_err !== 1'b0 || ram_re !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0)
        $display("FAIL cmd_err_after got err=%b re=%b busy=%b v=%b want 0/0/0/0", cmd_err, ram_re, busy, out_valid);
      else passed++;
    end
`endif
  endtask

  task automatic test_zero_len;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = 3'd1; cmd_len = 4'd0;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (ram_re !== 1'b0 || out_valid !== 1'b0 || cmd_ready !== 1'b1 || cmd_err !== 1'b0)
        $display("FAIL zero_len got re=%b v=%b rdy=%b err=%b want 0/0/1/0", ram_re, out_valid, cmd_ready, cmd_err);
      else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_busy_ignore;
    run_burst(1, 3, 1, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_burst;
    int hs = 0;
    int k = 0;
    out_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = 3'd0; cmd_len = 4'd8;
    @(negedge clk);
    cmd_valid = 1'b0;
    while (hs < 2 && k < 20) begin
      #1;
      if (out_valid && out_ready) begin
        total++;
        if (out_data !== mem[hs]) $display("FAIL pre_reset_word got %h want %h", out_data, mem[hs]);
        else passed++;
        hs++;
      end
      @(negedge clk);
      k++;
    end
    if (hs < 2) begin
      total++;
      $display("FAIL pre_reset_timeout got %0d words want 2", hs);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_values("reset_mid_burst");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0 || ram_re !== 1'b0 || busy !== 1'b0)
        $display("FAIL stale_after_reset got v=%b re=%b busy=%b want 0/0/0", out_valid, ram_re, busy);
      else passed++;
    end
    run_burst(3, 1, 0, 1'b0, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < MH; i++) mem[i] = 16'h1000 + 16'(i);
    test_reset();
    test_basic();
    test_backpressure();
    test_boundary();
    test_addr_overflow();
    test_zero_len();
    test_busy_ignore();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
